// File: rtl/alu_sequencer.sv
// Sequences one calculator request through the shared ALU with a response timeout,
// then streams the signed decimal result (or "ERR") to the UART TX path, ending in CR LF.
module alu_sequencer #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [7:0]  num_a,
   input  logic [7:0]  num_b,
   input  logic [3:0]  op,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [1:0]  alu_op,
   output logic        alu_start,
   input  logic        alu_valid,
   input  logic [15:0] alu_result,
   input  logic        alu_div0,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        overrun
);

   typedef enum logic [3:0] {
      IDLE, ISSUE, WAIT, CONV, SEND_SIGN, SEND_DIG, SEND_CR, SEND_LF, SEND_ERR
   } state_t;

   state_t      state_reg;
   logic [7:0]  tmo_cnt_reg;
   logic [15:0] mag_reg;
   logic        neg_reg;
   logic [2:0]  wgt_idx_reg;
   logic [3:0]  dcnt_reg;
   logic [3:0]  digit_reg [5];
   logic [2:0]  dig_idx_reg;
   logic [1:0]  err_idx_reg;

   logic [3:0]  digit_nz;
   logic [2:0]  lead_idx;
   logic [2:0]  dig_inc;
   logic [3:0]  first_digit;
   logic [15:0] weight;
   logic [15:0] res_mag;
   logic        tx_fire;

   function automatic logic [7:0] ascii_digit(input logic [3:0] d);
      return 8'h30 + {4'h0, d};
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_nz
         assign digit_nz[gi] = (digit_reg[gi] != 4'd0);
      end
   endgenerate

   // First significant digit; the units position is always printed.
   always_comb begin
      lead_idx = 3'd4;
      for (int i = 3; i >= 0; i--) begin
         if (digit_nz[i]) lead_idx = 3'(i);
      end
   end

   // The units digit is still in dcnt_reg on the cycle conversion completes.
   always_comb begin
      first_digit = dcnt_reg;
      if (lead_idx != 3'd4) first_digit = digit_reg[lead_idx];
   end

   always_comb begin
      case (wgt_idx_reg)
         3'd0:    weight = 16'd10000;
         3'd1:    weight = 16'd1000;
         3'd2:    weight = 16'd100;
         3'd3:    weight = 16'd10;
         default: weight = 16'd1;
      endcase
   end

   assign dig_inc = (dig_idx_reg >= 3'd4) ? 3'd4 : dig_idx_reg + 3'd1;
   assign res_mag = alu_result[15] ? (~alu_result + 16'd1) : alu_result;
   assign tx_fire = tx_valid && tx_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= IDLE;
         alu_a       <= 8'd0;
         alu_b       <= 8'd0;
         alu_op      <= 2'd0;
         alu_start   <= 1'b0;
         tx_data     <= 8'd0;
         tx_valid    <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         tmo_cnt_reg <= 8'd0;
         mag_reg     <= 16'd0;
         neg_reg     <= 1'b0;
         wgt_idx_reg <= 3'd0;
         dcnt_reg    <= 4'd0;
         dig_idx_reg <= 3'd0;
         err_idx_reg <= 2'd0;
         for (int i = 0; i < 5; i++) digit_reg[i] <= 4'd0;
      end else begin
         overrun   <= req_valid && (state_reg != IDLE);
         alu_start <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  alu_a  <= num_a;
                  alu_b  <= num_b;
                  alu_op <= op[1:0];
                  busy   <= 1'b1;
                  if (op <= 4'd3) begin
                     state_reg <= ISSUE;
                     alu_start <= 1'b1;
                  end else begin
                     state_reg   <= SEND_ERR;
                     err_idx_reg <= 2'd0;
                     tx_valid    <= 1'b1;
                     tx_data     <= 8'h45;
                  end
               end
            end
            ISSUE: begin
               state_reg   <= WAIT;
               tmo_cnt_reg <= 8'd1;
            end
            WAIT: begin
               if (alu_valid && alu_div0) begin
                  state_reg   <= SEND_ERR;
                  err_idx_reg <= 2'd0;
                  tx_valid    <= 1'b1;
                  tx_data     <= 8'h45;
               end else if (alu_valid) begin
                  state_reg   <= CONV;
                  neg_reg     <= alu_result[15];
                  mag_reg     <= res_mag;
                  wgt_idx_reg <= 3'd0;
                  dcnt_reg    <= 4'd0;
               end else if (tmo_cnt_reg == 8'(TIMEOUT - 1)) begin
                  state_reg   <= SEND_ERR;
                  err_idx_reg <= 2'd0;
                  tx_valid    <= 1'b1;
                  tx_data     <= 8'h45;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
               end
            end
            CONV: begin
               if (mag_reg >= weight) begin
                  mag_reg  <= mag_reg - weight;
                  dcnt_reg <= dcnt_reg + 4'd1;
               end else begin
                  digit_reg[wgt_idx_reg] <= dcnt_reg;
                  dcnt_reg               <= 4'd0;
                  if (wgt_idx_reg == 3'd4) begin
                     dig_idx_reg <= lead_idx;
                     tx_valid    <= 1'b1;
                     if (neg_reg) begin
                        state_reg <= SEND_SIGN;
                        tx_data   <= 8'h2D;
                     end else begin
                        state_reg <= SEND_DIG;
                        tx_data   <= ascii_digit(first_digit);
                     end
                  end else begin
                     wgt_idx_reg <= wgt_idx_reg + 3'd1;
                  end
               end
            end
            SEND_SIGN: begin
               if (tx_fire) begin
                  state_reg <= SEND_DIG;
                  tx_data   <= ascii_digit(digit_reg[dig_idx_reg]);
               end
            end
            SEND_DIG: begin
               if (tx_fire) begin
                  if (dig_idx_reg == 3'd4) begin
                     state_reg <= SEND_CR;
                     tx_data   <= 8'h0D;
                  end else begin
                     dig_idx_reg <= dig_inc;
                     tx_data     <= ascii_digit(digit_reg[dig_inc]);
                  end
               end
            end
            SEND_ERR: begin
               if (tx_fire) begin
                  if (err_idx_reg == 2'd2) begin
                     state_reg <= SEND_CR;
                     tx_data   <= 8'h0D;
                  end else begin
                     err_idx_reg <= err_idx_reg + 2'd1;
                     tx_data     <= 8'h52;
                  end
               end
            end
            SEND_CR: begin
               if (tx_fire) begin
                  state_reg <= SEND_LF;
                  tx_data   <= 8'h0A;
               end
            end
            SEND_LF: begin
               if (tx_fire) begin
                  state_reg <= IDLE;
                  tx_valid  <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: vector table for full requests plus hand-written
// sequences for timeout, back-to-back, overrun, stall and mid-operation reset.
module tb_alu_sequencer;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [7:0]  num_a;
   logic [7:0]  num_b;
   logic [3:0]  op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [1:0]  alu_op;
   logic        alu_start;
   logic        alu_valid;
   logic [15:0] alu_result;
   logic        alu_div0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        overrun;

   alu_sequencer #(.TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .num_a(num_a), .num_b(num_b), .op(op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
      .alu_valid(alu_valid), .alu_result(alu_result), .alu_div0(alu_div0),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .overrun(overrun)
   );

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [3:0]  op;
      bit          resp;
      logic [15:0] res;
      logic        div0;
      int          n;
      logic [63:0] bytes_exp;
      int          mode;
   } vec_t;

   vec_t vecs [10];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int start_cnt = 0;
   int start_cyc = 0;
   int last_tx_cyc = 0;
   int ovr_cnt = 0;
   int stab_checks = 0;
   int stab_viol = 0;
   int ready_mode = 0;
   int ph = 0;
   bit chk_stable = 1;
   bit prev_stall = 0;
   logic [7:0] prev_data = 8'd0;
   logic [7:0] rx_q [$];

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      tx_ready = 0;
      forever begin
         @(posedge clk);
         #1;
         ph++;
         tx_ready = (ready_mode == 0) || (ph % 3 == 0);
      end
   end

   // Observes the TX stream, ALU starts, overruns and stall stability.
   always @(negedge clk) begin
      if (alu_start) begin
         start_cnt++;
         start_cyc = cyc;
      end
      if (tx_valid && tx_ready) begin
         rx_q.push_back(tx_data);
         last_tx_cyc = cyc;
      end
      if (overrun) ovr_cnt++;
      if (chk_stable && prev_stall) begin
         stab_checks++;
         if (!(tx_valid && tx_data == prev_data)) stab_viol++;
      end
      prev_stall = chk_stable && tx_valid && !tx_ready;
      prev_data  = tx_data;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   task automatic nedge();
      @(negedge clk);
      #1;
   endtask

   task automatic send_req(input logic [7:0] a, input logic [7:0] b, input logic [3:0] o);
      @(posedge clk);
      #1;
      req_valid = 1;
      num_a = a;
      num_b = b;
      op = o;
      @(posedge clk);
      #1;
      req_valid = 0;
   endtask

   task automatic check_issue(input string name, input bit exp_start,
                              input logic [7:0] a, input logic [7:0] b, input logic [3:0] o);
      nedge();
      check({name, " busy"}, busy, 1);
      check({name, " start"}, alu_start, exp_start);
      if (exp_start) begin
         check({name, " alu_a"}, alu_a, a);
         check({name, " alu_b"}, alu_b, b);
         check({name, " alu_op"}, alu_op, o[1:0]);
      end
   endtask

   task automatic alu_respond(input string name, input logic [15:0] res, input logic div0,
                              input logic [7:0] a, input logic [7:0] b);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      alu_valid = 1;
      alu_result = res;
      alu_div0 = div0;
      check({name, " hold_a"}, alu_a, a);
      check({name, " hold_b"}, alu_b, b);
      @(posedge clk);
      #1;
      alu_valid = 0;
      alu_div0 = 0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 400) begin
         nedge();
         n++;
      end
      check({name, " idle"}, busy, 0);
      check({name, " busy_fall"}, cyc - last_tx_cyc, 1);
   endtask

   task automatic check_bytes(input string name, input logic [63:0] want, input int n);
      logic [7:0] e;
      logic [7:0] g;
      check({name, " len"}, rx_q.size(), n);
      for (int k = 0; k < n; k++) begin
         e = want[63 - 8*k -: 8];
         g = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
         check($sformatf("%s byte%0d", name, k), g, e);
      end
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      int s0;
      int sv0;
      string nm;
      v = vecs[i];
      nm = $sformatf("vec%0d", i);
      rx_q.delete();
      ready_mode = v.mode;
      s0 = start_cnt;
      sv0 = stab_viol;
      send_req(v.a, v.b, v.op);
      check_issue(nm, v.op <= 4'd3, v.a, v.b, v.op);
      if (v.resp) alu_respond(nm, v.res, v.div0, v.a, v.b);
      wait_idle(nm);
      check_bytes(nm, v.bytes_exp, v.n);
      check({nm, " starts"}, start_cnt - s0, (v.op <= 4'd3) ? 1 : 0);
      check({nm, " stable"}, stab_viol - sv0, 0);
      $display("vec %0d: op=%0d a=%0d b=%0d res=%0h bytes=%0d", i, v.op, v.a, v.b, v.res, rx_q.size());
   endtask

   initial begin
      int s;
      int n;
      int o0;
      int s0;
      int sc0;

      vecs[0] = '{8'd12,  8'd34,  4'd0, 1'b1, 16'd46,    1'b0, 4, 64'h34360D0A00000000, 0};
      vecs[1] = '{8'd5,   8'd9,   4'd1, 1'b1, 16'hFFFC,  1'b0, 4, 64'h2D340D0A00000000, 0};
      vecs[2] = '{8'd7,   8'd7,   4'd1, 1'b1, 16'd0,     1'b0, 3, 64'h300D0A0000000000, 0};
      vecs[3] = '{8'd255, 8'd255, 4'd2, 1'b1, 16'hFE01,  1'b0, 6, 64'h2D3531310D0A0000, 1};
      vecs[4] = '{8'd10,  8'd0,   4'd3, 1'b1, 16'd0,     1'b1, 5, 64'h4552520D0A000000, 0};
      vecs[5] = '{8'd1,   8'd2,   4'd9, 1'b0, 16'd0,     1'b0, 5, 64'h4552520D0A000000, 0};
      vecs[6] = '{8'd200, 8'd100, 4'd0, 1'b1, 16'd300,   1'b0, 5, 64'h3330300D0A000000, 1};
      vecs[7] = '{8'd128, 8'd0,   4'd2, 1'b1, 16'h8000,  1'b0, 8, 64'h2D33323736380D0A, 0};
      vecs[8] = '{8'd127, 8'd1,   4'd0, 1'b1, 16'h7FFF,  1'b0, 7, 64'h33323736370D0A00, 0};
      vecs[9] = '{8'd4,   8'd6,   4'd0, 1'b1, 16'd10,    1'b0, 4, 64'h31300D0A00000000, 1};

      rst = 0;
      req_valid = 1;
      num_a = 8'h11;
      num_b = 8'h22;
      op = 4'd0;
      alu_valid = 0;
      alu_result = 16'd0;
      alu_div0 = 0;
      repeat (3) @(posedge clk);
      nedge();
      check("rst busy", busy, 0);
      check("rst tx_valid", tx_valid, 0);
      check("rst alu_start", alu_start, 0);
      check("rst overrun", overrun, 0);
      check("rst tx_data", tx_data, 0);
      check("rst alu_a", alu_a, 0);
      check("rst alu_b", alu_b, 0);
      check("rst alu_op", alu_op, 0);
      @(posedge clk);
      #1;
      rst = 1;
      req_valid = 0;
      nedge();
      check("rst req ignored busy", busy, 0);
      check("rst req ignored start", alu_start, 0);
      $display("reset: outputs cleared, coincident request ignored");

      for (int i = 0; i < 10; i++) run_vec(i);

      sc0 = stab_checks;
      run_vec(3);
      check("stall exercised", (stab_checks > sc0) ? 1 : 0, 1);

      // Back-to-back: a request in the first IDLE cycle after LF is accepted.
      rx_q.delete();
      ready_mode = 0;
      o0 = ovr_cnt;
      send_req(8'd200, 8'd100, 4'd0);
      check_issue("b2b first", 1, 8'd200, 8'd100, 4'd0);
      alu_respond("b2b first", 16'd300, 1'b0, 8'd200, 8'd100);
      n = 0;
      while (!(rx_q.size() > 0 && rx_q[rx_q.size()-1] == 8'h0A) && n < 200) begin
         nedge();
         n++;
      end
      check_bytes("b2b first", 64'h3330300D0A000000, 5);
      rx_q.delete();
      send_req(8'd12, 8'd34, 4'd0);
      check_issue("b2b second", 1, 8'd12, 8'd34, 4'd0);
      alu_respond("b2b second", 16'd46, 1'b0, 8'd12, 8'd34);
      wait_idle("b2b second");
      check_bytes("b2b second", 64'h34360D0A00000000, 4);
      check("b2b no overrun", ovr_cnt - o0, 0);
      $display("b2b: second request accepted in idle cycle after LF");

      // Timeout: ERR appears TIMEOUT cycles after alu_start; late response ignored.
      rx_q.delete();
      send_req(8'd3, 8'd4, 4'd0);
      check_issue("tmo", 1, 8'd3, 8'd4, 4'd0);
      s = start_cyc;
      n = 0;
      while (!tx_valid && n < 40) begin
         nedge();
         n++;
      end
      check("tmo delay", cyc - s, 8);
      check("tmo first byte", tx_data, 8'h45);
      @(posedge clk);
      #1;
      alu_valid = 1;
      alu_result = 16'd46;
      @(posedge clk);
      #1;
      alu_valid = 0;
      wait_idle("tmo");
      check_bytes("tmo", 64'h4552520D0A000000, 5);
      $display("tmo: ERR after %0d cycles, late valid ignored", 8);
      run_vec(0);

      // Overrun during SEND_DIG with a stalling receiver.
      rx_q.delete();
      ready_mode = 1;
      o0 = ovr_cnt;
      s0 = start_cnt;
      send_req(8'd255, 8'd255, 4'd2);
      check_issue("ovr", 1, 8'd255, 8'd255, 4'd2);
      alu_respond("ovr", 16'hFE01, 1'b0, 8'd255, 8'd255);
      n = 0;
      while (rx_q.size() < 1 && n < 200) begin
         nedge();
         n++;
      end
      @(posedge clk);
      #1;
      req_valid = 1;
      num_a = 8'd1;
      num_b = 8'd1;
      op = 4'd0;
      @(posedge clk);
      #1;
      req_valid = 0;
      nedge();
      check("ovr pulse", overrun, 1);
      nedge();
      check("ovr pulse end", overrun, 0);
      wait_idle("ovr");
      check_bytes("ovr", 64'h2D3531310D0A0000, 6);
      check("ovr count", ovr_cnt - o0, 1);
      check("ovr starts", start_cnt - s0, 1);
      $display("ovr: dropped request flagged, output -511 intact");

      // Reset in the middle of SEND_DIG, then a fresh request.
      rx_q.delete();
      ready_mode = 1;
      send_req(8'd100, 8'd23, 4'd0);
      check_issue("mrst", 1, 8'd100, 8'd23, 4'd0);
      alu_respond("mrst", 16'd12345, 1'b0, 8'd100, 8'd23);
      n = 0;
      while (rx_q.size() < 2 && n < 200) begin
         nedge();
         n++;
      end
      check("mrst in digits", (rx_q.size() >= 2 && tx_valid) ? 1 : 0, 1);
      chk_stable = 0;
      @(posedge clk);
      #1;
      rst = 0;
      @(posedge clk);
      #1;
      rst = 1;
      nedge();
      check("mrst tx_valid", tx_valid, 0);
      check("mrst busy", busy, 0);
      chk_stable = 1;
      $display("mrst: request abandoned by reset");
      run_vec(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
